// File: rtl/mul_div_if.sv
`timescale 1ns/1ps
// mul_div_if
//  Request/response bundle between the execute stage and the iterative
//  multiply/divide unit.
//  master (execute stage): drives start, op, a, b, cancel, hi_we, lo_we, wdata
//  slave  (mul_div_unit) : drives hi, lo, busy, done, div_zero
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b, cancel, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b, cancel, hi_we, lo_we, wdata,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
`timescale 1ns/1ps
// mul_div_unit
//  Iterative radix-2 multiply/divide unit with HI/LO result registers.
//  Operands are converted to magnitudes on accept, processed unsigned for
//  WIDTH clocks (shift-add or restoring shift-subtract), then sign-corrected
//  in a final FIX cycle that writes HI/LO.
//  Ports:
//   clk   rising-edge clock
//   clrn  asynchronous active-low reset
//   bus   mul_div_if.slave: start/op/a/b/cancel request, hi_we/lo_we/wdata
//         direct HI/LO writes, hi/lo/busy/done/div_zero status
//  op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (op[1] = divide, op[0] = unsigned)
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     clrn,
  mul_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             op_div;   // current op is a divide
  logic             neg_q;    // product / quotient must be negated
  logic             neg_r;    // remainder must be negated (takes sign of a)
  logic             dz_pend;  // divide with zero divisor in flight
  logic [WIDTH-1:0] m;        // |multiplicand| or |divisor|
  logic [WIDTH-1:0] r_hi;     // partial product high / partial remainder
  logic [WIDTH-1:0] r_lo;     // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  // Operand magnitudes for signed ops, computed at accept.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
  assign a_abs = a_neg ? -bus.a : bus.a;
  assign b_abs = b_neg ? -bus.b : bus.b;

  // One iteration of the shared datapath.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] r_hi_nx, r_lo_nx;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    r_hi_nx   = r_hi;
    r_lo_nx   = r_lo;
    mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, m} : '0);
    div_shift = {r_hi, r_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m};
    if (op_div) begin
      // Partial remainder stays below m, so bit WIDTH of the difference is
      // set exactly when the trial subtraction underflows.
      if (!div_diff[WIDTH]) begin
        r_hi_nx = div_diff[WIDTH-1:0];
        r_lo_nx = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        r_hi_nx = div_shift[WIDTH-1:0];
        r_lo_nx = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      r_hi_nx = mul_sum[WIDTH:1];
      r_lo_nx = {mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
  // With a zero divisor every trial subtraction succeeds, so the remainder
  // ends as |a|; negating by sign(a) restores the raw dividend for hi.
  assign quo_fix  = dz_pend ? '1 : (neg_q ? -r_lo : r_lo);
  assign rem_fix  = neg_r ? -r_hi : r_hi;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_pend <= 1'b0;
      m       <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // MTHI/MTLO only while idle; an accepted op later overwrites HI/LO.
      if (state == S_IDLE) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end

      case (state)
        S_IDLE: begin
          if (bus.start && !bus.cancel) begin
            op_div  <= bus.op[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg & bus.op[1];
            dz_pend <= bus.op[1] && (bus.b == '0);
            dz_q    <= 1'b0;
            cnt     <= '0;
            if (bus.op[1]) begin
              m    <= b_abs;
              r_hi <= '0;
              r_lo <= a_abs;
            end else begin
              m    <= a_abs;
              r_hi <= '0;
              r_lo <= b_abs;
            end
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (bus.cancel) begin
            state <= S_IDLE;
          end else begin
            r_hi <= r_hi_nx;
            r_lo <= r_lo_nx;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!bus.cancel) begin
            if (op_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
            dz_q   <= dz_pend;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule
